// File: rtl/program_sequencer.sv
// program_sequencer: 8-bit fetch sequencer with JMP/JNZ redirect,
// stall hold and a saturating retired-word counter.
module program_sequencer #(
  parameter logic [7:0] RESET_VECTOR = 8'h00,
  parameter int         CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             zero_flag,
  input  logic [7:0]       pm_data,
  output logic [7:0]       pm_addr,
  output logic [7:0]       ir,
  output logic [7:0]       ir_pc,
  output logic             ir_valid,
  output logic             jump_taken,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_FILL,
    ST_RUN,
    ST_STALL
  } state_t;

  state_t     r_state;
  logic [7:0] r_pc;
  logic       r_fetch_valid;

  logic [3:0] w_op;
  logic [3:0] w_imm;
  logic [7:0] w_target;
  logic [7:0] w_pc_inc;
  logic       w_jmp;
  logic       w_jnz;
  logic       w_taken;
  logic       w_hold;
  logic       w_retire;
  logic       w_cnt_sat;

  assign w_op      = pm_data[7:4];
  assign w_imm     = pm_data[3:0];
  assign w_target  = {w_imm, 4'h0};
  assign w_pc_inc  = r_pc + 8'd1;
  assign w_jmp     = (w_op == 4'hE);
  assign w_jnz     = (w_op == 4'hF);
  assign w_taken   = w_jmp | (w_jnz & ~zero_flag);
  assign w_cnt_sat = &retired_cnt;

  assign w_hold = (r_state == ST_FILL)
                | (r_state == ST_STALL)
                | stall;

  assign w_retire = (r_state == ST_RUN)
                  & r_fetch_valid
                  & ~stall;

  // Stall outranks any redirect: a held jump word re-reads pc.
  always_comb begin
    pm_addr = r_pc;
    if (!reset_n || (r_state == ST_RESET)) begin
      pm_addr = RESET_VECTOR;
    end else if (w_hold) begin
      pm_addr = r_pc;
    end else if (w_retire && w_taken) begin
      pm_addr = w_target;
    end else if (w_retire) begin
      pm_addr = w_pc_inc;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state       <= ST_RESET;
      r_pc          <= RESET_VECTOR;
      r_fetch_valid <= 1'b0;
      ir            <= 8'h00;
      ir_pc         <= 8'h00;
      ir_valid      <= 1'b0;
      jump_taken    <= 1'b0;
      retired_cnt   <= '0;
    end else begin
      r_pc          <= pm_addr;
      r_fetch_valid <= 1'b1;
      unique case (r_state)
        ST_RESET: r_state <= ST_FILL;
        ST_FILL:  r_state <= ST_RUN;
        ST_RUN,
        ST_STALL: r_state <= stall ? ST_STALL : ST_RUN;
        default:  r_state <= ST_RESET;
      endcase
      ir_valid   <= w_retire;
      jump_taken <= w_retire & w_taken;
      if (w_retire) begin
        ir    <= pm_data;
        ir_pc <= r_pc;
        if (!w_cnt_sat) begin
          retired_cnt <= retired_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: vector table, directed corner
// sequences and random stall/zero/reset against a reference model.
module tb_program_sequencer;

  localparam logic [7:0] RV = 8'h00;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        zero_flag;
  logic [7:0]  pm_data;
  logic [7:0]  pm_addr;
  logic [7:0]  ir;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        jump_taken;
  logic [15:0] retired_cnt;

  logic [7:0]  pm_data4;
  logic [7:0]  pm_addr4;
  logic [7:0]  ir4;
  logic [7:0]  ir_pc4;
  logic        ir_valid4;
  logic        jump_taken4;
  logic [3:0]  retired_cnt4;

  logic [7:0]  rom [256];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    pm_data  <= rom[pm_addr];
    pm_data4 <= rom[pm_addr4];
  end

  program_sequencer #(.RESET_VECTOR(RV), .CNT_W(16)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .stall       (stall),
    .zero_flag   (zero_flag),
    .pm_data     (pm_data),
    .pm_addr     (pm_addr),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid),
    .jump_taken  (jump_taken),
    .retired_cnt (retired_cnt)
  );

  program_sequencer #(.RESET_VECTOR(RV), .CNT_W(4)) dut4 (
    .clock       (clock),
    .reset_n     (reset_n),
    .stall       (stall),
    .zero_flag   (zero_flag),
    .pm_data     (pm_data4),
    .pm_addr     (pm_addr4),
    .ir          (ir4),
    .ir_pc       (ir_pc4),
    .ir_valid    (ir_valid4),
    .jump_taken  (jump_taken4),
    .retired_cnt (retired_cnt4)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t: got %0h want %0h",
                  nm, $time, act, exp);
  endtask

  // Reference model: pm_data always shows rom[pc]; cycles since
  // reset release give RESET (0), FILL (1), then running.
  int         m_age;
  logic [7:0] m_pc, m_ir, m_irpc;
  logic       m_irv, m_jt, m_prev_stall, m_live = 1'b0;
  int         m_cnt, m_cnt4;
  logic [7:0] e_addr, e_word;
  logic       e_ret, e_tkn;

  task automatic model_eval();
    logic held;
    e_word = rom[m_pc];
    e_tkn  = (e_word[7:4] == 4'hE)
          || (e_word[7:4] == 4'hF && !zero_flag);
    held   = (m_age >= 3) && m_prev_stall;
    e_ret  = reset_n && (m_age >= 2) && !held && !stall;
    if (!reset_n || m_age == 0) e_addr = RV;
    else if (!e_ret)            e_addr = m_pc;
    else if (e_tkn)             e_addr = {e_word[3:0], 4'h0};
    else                        e_addr = m_pc + 8'd1;
    if (m_live) begin
      chk("m_addr",  pm_addr,      e_addr);
      chk("m_addr4", pm_addr4,     e_addr);
      chk("m_ir",    ir,           m_ir);
      chk("m_irpc",  ir_pc,        m_irpc);
      chk("m_irv",   ir_valid,     m_irv);
      chk("m_jt",    jump_taken,   m_jt);
      chk("m_cnt",   retired_cnt,  m_cnt);
      chk("m_cnt4",  retired_cnt4, m_cnt4);
    end
  endtask

  task automatic model_step();
    if (!reset_n) begin
      m_age = 0; m_pc = RV; m_ir = 8'h00; m_irpc = 8'h00;
      m_irv = 0; m_jt = 0; m_cnt = 0; m_cnt4 = 0;
      m_prev_stall = 0; m_live = 1'b1;
    end else begin
      m_irv = e_ret;
      m_jt  = e_ret && e_tkn;
      if (e_ret) begin
        m_ir   = e_word;
        m_irpc = m_pc;
        if (m_cnt  < 65535) m_cnt++;
        if (m_cnt4 < 15)    m_cnt4++;
      end
      m_prev_stall = (m_age >= 2) && stall;
      m_pc = e_addr;
      if (m_age < 3) m_age++;
    end
  endtask

  task automatic cycle();
    @(negedge clock);
    model_eval();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic wait_irpc(input logic [7:0] pc, input int lim,
                           input string nm);
    logic hit = 1'b0;
    for (int k = 0; k < lim && !hit; k++) begin
      cycle();
      hit = ir_valid && (ir_pc == pc);
    end
    chk(nm, hit, 1'b1);
  endtask

  typedef struct {
    logic       stall;
    logic       irv;
    logic [7:0] irpc;
    logic [7:0] ir;
    logic       jt;
    logic [7:0] addr;
  } vec_t;

  vec_t tbl [7];

  initial begin
    tbl[0] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h01};
    tbl[1] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h02};
    tbl[2] = '{1'b0, 1'b1, 8'h01, 8'h10, 1'b0, 8'h03};
    tbl[3] = '{1'b0, 1'b1, 8'h02, 8'h21, 1'b0, 8'h04};
    tbl[4] = '{1'b0, 1'b1, 8'h03, 8'h3F, 1'b0, 8'h10};
    tbl[5] = '{1'b0, 1'b1, 8'h04, 8'hE1, 1'b1, 8'h11};
    tbl[6] = '{1'b0, 1'b1, 8'h10, 8'h55, 1'b0, 8'h12};

    for (int i = 0; i < 256; i++) rom[i] = 8'h11;
    rom[8'h00] = 8'h00; rom[8'h01] = 8'h10; rom[8'h02] = 8'h21;
    rom[8'h03] = 8'h3F; rom[8'h04] = 8'hE1; rom[8'h10] = 8'h55;
    rom[8'h12] = 8'hE2; rom[8'h24] = 8'hF2; rom[8'h25] = 8'hEF;

    reset_n = 1'b0; stall = 1'b0; zero_flag = 1'b1;
    cycle();
    cycle();
    chk("rst_irv",  ir_valid,    1'b0);
    chk("rst_ir",   ir,          8'h00);
    chk("rst_irpc", ir_pc,       8'h00);
    chk("rst_jt",   jump_taken,  1'b0);
    chk("rst_cnt",  retired_cnt, 16'h0);
    chk("rst_addr", pm_addr,     RV);
    reset_n = 1'b1;
    #1 chk("reset_state_addr", pm_addr, RV);
    cycle();
    chk("fill_addr", pm_addr,  RV);
    chk("fill_irv",  ir_valid, 1'b0);

    for (int i = 0; i < 7; i++) begin
      stall = tbl[i].stall;
      cycle();
      chk($sformatf("tbl%0d_irv", i),  ir_valid,   tbl[i].irv);
      chk($sformatf("tbl%0d_irpc", i), ir_pc,      tbl[i].irpc);
      chk($sformatf("tbl%0d_ir", i),   ir,         tbl[i].ir);
      chk($sformatf("tbl%0d_jt", i),   jump_taken, tbl[i].jt);
      chk($sformatf("tbl%0d_addr", i), pm_addr,    tbl[i].addr);
    end
    chk("cnt_after_tbl", retired_cnt, 16'd6);

    stall = 1'b1;
    #1 chk("stall_addr_in", pm_addr, 8'h11);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_addr", pm_addr,     8'h11);
      chk("stall_irv",  ir_valid,    1'b0);
      chk("stall_cnt",  retired_cnt, 16'd6);
    end
    stall = 1'b0;
    #1 chk("release_addr", pm_addr, 8'h11);
    wait_irpc(8'h11, 4, "release_irpc11");

    wait_irpc(8'h23, 40, "reach_23");
    zero_flag = 1'b0; stall = 1'b1;
    #1 chk("jnz_stalled_addr", pm_addr, 8'h24);
    cycle();
    chk("jnz_stalled_jt",  jump_taken, 1'b0);
    chk("jnz_stalled_irv", ir_valid,   1'b0);
    stall = 1'b0;
    #1 chk("jnz_release_addr", pm_addr, 8'h24);
    cycle();
    chk("jnz_taken_addr", pm_addr, 8'h20);
    cycle();
    chk("jnz_irpc", ir_pc,      8'h24);
    chk("jnz_ir",   ir,         8'hF2);
    chk("jnz_jt",   jump_taken, 1'b1);
    cycle();
    chk("jnz_next_irpc", ir_pc, 8'h20);

    wait_irpc(8'h23, 10, "reach_23b");
    zero_flag = 1'b1;
    #1 chk("jnz_nt_addr", pm_addr, 8'h25);
    cycle();
    chk("jnz_nt_irpc", ir_pc,      8'h24);
    chk("jnz_nt_jt",   jump_taken, 1'b0);
    cycle();
    chk("jnz_nt_next", ir_pc, 8'h25);

    wait_irpc(8'hFE, 40, "reach_FE");
    chk("wrap_addr", pm_addr, 8'h00);
    cycle();
    chk("wrap_irpc_ff", ir_pc, 8'hFF);
    cycle();
    chk("wrap_irpc_00", ir_pc, 8'h00);

    chk("cnt_ge20",  retired_cnt >= 16'd20, 1'b1);
    chk("cnt4_sat",  retired_cnt4,          4'hF);

    wait_irpc(8'h11, 40, "reach_11");
    chk("jmp_pre_addr", pm_addr, 8'h20);
    reset_n = 1'b0;
    #1 chk("jmp_rst_addr", pm_addr, RV);
    cycle();
    chk("jmp_rst_irv",  ir_valid,    1'b0);
    chk("jmp_rst_jt",   jump_taken,  1'b0);
    chk("jmp_rst_cnt",  retired_cnt, 16'h0);
    reset_n = 1'b1;
    cycle();
    cycle();
    chk("rerun_no_retire", ir_valid, 1'b0);
    cycle();
    chk("rerun_irv",  ir_valid, 1'b1);
    chk("rerun_irpc", ir_pc,    8'h00);

    reset_n = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    cycle();
    reset_n = 1'b1;
    for (int i = 0; i < 800; i++) begin
      stall     = ($urandom % 4) == 0;
      zero_flag = 1'($urandom);
      reset_n   = ($urandom % 64) != 0;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
